// File: rtl/button_pkg.sv
// button_pkg: shared FSM state encoding and LED reset pattern for button_reader
package button_pkg;
  typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} state_t;
  localparam logic [3:0] LED_RESET = 4'b0001;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input
//   clk : sampling clock
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk edges behind d
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= {RESET_VAL, RESET_VAL};
    else     {q, meta} <= {meta, d};
endmodule

// File: rtl/button_reader.sv
// button_reader: debounced push-button reader with press/release strobes and a press-position LED ring
//   clk           : system clock
//   rst           : synchronous active-high reset
//   btn           : raw bouncing button pin (reads 0 when pressed if ACTIVE_LOW)
//   pressed       : debounced level, 1 while held
//   press_pulse   : one-cycle strobe on accepted press
//   release_pulse : one-cycle strobe on accepted release
//   D1..D4        : one-hot LED, advances on each accepted press
//   D5            : mirrors pressed
module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic btn_s, s, pressed_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] led;
  state_t state, state_n;
  // flops reset to the idle pin level so reset never looks like a press
  sync2 #(.RESET_VAL(ACTIVE_LOW)) u_sync (.clk(clk), .rst(rst), .d(btn), .q(btn_s));
  assign s = btn_s ^ ACTIVE_LOW;
  // counter clears on every state change, so it never passes LAST
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE:        state_n = s ? ARM_PRESS : IDLE;
      ARM_PRESS: begin
        state_n = !s ? IDLE : (cnt == LAST ? HELD : ARM_PRESS);
        cnt_n   = (s && cnt != LAST) ? cnt + CW'(1) : '0;
      end
      HELD:        state_n = s ? HELD : ARM_RELEASE;
      ARM_RELEASE: begin
        state_n = s ? HELD : (cnt == LAST ? IDLE : ARM_RELEASE);
        cnt_n   = (!s && cnt != LAST) ? cnt + CW'(1) : '0;
      end
      default:     state_n = IDLE;
    endcase
    pressed_n = (state_n == HELD) || (state_n == ARM_RELEASE);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      led           <= LED_RESET;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      pressed       <= pressed_n;
      press_pulse   <= pressed_n & ~pressed;
      release_pulse <= ~pressed_n & pressed;
      led           <= (pressed_n & ~pressed) ? {led[2:0], led[3]} : led;
    end
  assign {D4, D3, D2, D1} = led;
  assign D5 = pressed;
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: scoreboard-driven bench for button_reader with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1
module tb_button_reader;
  localparam int LAT = 7;
  logic clk = 1'b0, rst = 1'b1, btn = 1'b1;
  logic pressed, press_pulse, release_pulse, D1, D2, D3, D4, D5;
  int cyc = 0, vectors = 0, errors = 0, n_press = 0, n_rel = 0;
  typedef struct {int at; bit rel;} ev_t;
  ev_t q[$];
  ev_t ev;
  logic [3:0] m_led = 4'b0001;
  logic m_pressed = 1'b0;

  button_reader #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .btn(btn), .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse scoreboard: every strobe must match the oldest expected event exactly in cycle and kind
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_led = 4'b0001;
      m_pressed = 1'b0;
    end else if (press_pulse || release_pulse) begin
      n_press += int'(press_pulse);
      n_rel += int'(release_pulse);
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b want none", cyc, press_pulse, release_pulse);
      end else begin
        ev = q.pop_front();
        if (ev.at != cyc || release_pulse !== ev.rel || press_pulse !== !ev.rel) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d press=%b release=%b want cyc=%0d release=%b",
                   cyc, press_pulse, release_pulse, ev.at, ev.rel);
        end
        if (!ev.rel) m_led = {m_led[2:0], m_led[3]};
        m_pressed = !ev.rel;
        vectors++;
        if ({D4, D3, D2, D1} !== m_led || pressed !== m_pressed || D5 !== m_pressed) begin
          errors++;
          $display("FAIL pulse_levels cyc=%0d got led=%b pressed=%b D5=%b want led=%b pressed=%b",
                   cyc, {D4, D3, D2, D1}, pressed, D5, m_led, m_pressed);
        end
      end
    end else if (q.size() > 0 && q[0].at < cyc) begin
      vectors++;
      errors++;
      $display("FAIL missing_pulse cyc=%0d got none want release=%b at cyc=%0d", cyc, q[0].rel, q[0].at);
      void'(q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic v, input bit expect_pulse);
    btn = v;
    if (expect_pulse) q.push_back('{cyc + LAT, v});
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({pressed, press_pulse, release_pulse, D5, D4, D3, D2, D1} !== 8'b0000_0001) begin
        errors++;
        $display("FAIL reset_values cyc=%0d got %b want 00000001", cyc,
                 {pressed, press_pulse, release_pulse, D5, D4, D3, D2, D1});
      end
      tick(1);
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] exp;
    while (cyc < 10) tick(1);
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      exp = {cyc == 17, cyc >= 17, cyc >= 17, cyc < 17, cyc >= 17};
      vectors++;
      if ({press_pulse, pressed, D5, D1, D2} !== exp) begin
        errors++;
        $display("FAIL clean_press cyc=%0d got pp/p/D5/D1/D2=%b want %b", cyc,
                 {press_pulse, pressed, D5, D1, D2}, exp);
      end
    end
  endtask

  task automatic test_release();
    int n;
    logic [3:0] exp;
    tick(2);
    n = cyc;
    set_btn(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      exp = {cyc == n + 7, cyc < n + 7, cyc < n + 7, 1'b1};
      vectors++;
      if ({release_pulse, pressed, D5, D2} !== exp || D1 !== 1'b0) begin
        errors++;
        $display("FAIL release cyc=%0d got rp/p/D5/D2=%b D1=%b want %b D1=0", cyc,
                 {release_pulse, pressed, D5, D2}, D1, exp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      set_btn(i[0], 1'b0);
      tick(2);
    end
    set_btn(1'b0, 1'b1);
    tick(10);
    vectors++;
    if (pressed !== 1'b1 || {D4, D3, D2, D1} !== 4'b0100) begin
      errors++;
      $display("FAIL bounce_press got pressed=%b led=%b want 1 0100", pressed, {D4, D3, D2, D1});
    end
    set_btn(1'b1, 1'b1);
    tick(10);
    vectors++;
    if (pressed !== 1'b0) begin
      errors++;
      $display("FAIL bounce_release got pressed=%b want 0", pressed);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int p0, r0;
    pulse_rst();
    p0 = n_press;
    r0 = n_rel;
    for (int i = 0; i < 4; i++) begin
      set_btn(1'b0, 1'b1);
      tick(9);
      vectors++;
      if ({D4, D3, D2, D1} !== seq[i] || pressed !== 1'b1) begin
        errors++;
        $display("FAIL wrap_led press=%0d got led=%b pressed=%b want %b 1", i, {D4, D3, D2, D1}, pressed, seq[i]);
      end
      set_btn(1'b1, 1'b1);
      tick(9);
    end
    vectors++;
    if (n_press - p0 != 4 || n_rel - r0 != 4) begin
      errors++;
      $display("FAIL wrap_count got press=%0d release=%0d want 4 4", n_press - p0, n_rel - r0);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        set_btn(1'b0, 1'b0);
        tick(5);
      end
      pulse_rst();
      vectors++;
      if ({pressed, press_pulse, release_pulse, D5, D4, D3, D2, D1} !== 8'b0000_0001) begin
        errors++;
        $display("FAIL reset_mid_values k=%0d got %b want 00000001", k,
                 {pressed, press_pulse, release_pulse, D5, D4, D3, D2, D1});
      end
      q.push_back('{cyc + LAT, 1'b0});
      tick(8);
      vectors++;
      if (pressed !== 1'b1 || {D4, D3, D2, D1} !== 4'b0010) begin
        errors++;
        $display("FAIL reset_mid_press k=%0d got pressed=%b led=%b want 1 0010", k, pressed, {D4, D3, D2, D1});
      end
    end
    set_btn(1'b1, 1'b1);
    tick(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_wrap();
    test_reset_mid();
    tick(3);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
